// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for sync_fifo_param.
//   FIFO_DATA_W / FIFO_DEPTH : default word width and entry count
//   ptr_width()              : pointer width for a depth (address bits + wrap bit)
//   fifo_ptr_t               : pointer layout (wrap bit + address) at the default depth
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                   wrap;
    logic [FIFO_ADDR_W-1:0] addr;
  } fifo_ptr_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param.
//   master : drives wr_en, data_in, rd_en, err_clr; observes data and status
//   slave  : the FIFO side of the same signals
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
);

  localparam int CNT_W = ptr_width(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W simple dual-port storage.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with fill level,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_param_if.slave (write/read handshake, data, status)
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// otherwise data_out is a registered read with 1-cycle latency.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  // MSB of each pointer is the wrap bit; low bits address storage.
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  count_i;
  logic              full_i, empty_i;
  logic              wr_acc, rd_acc;
  logic              overflow_q, underflow_q;
  logic [DATA_W-1:0] ram_rdata;

  // Modulo subtraction gives occupancy across the wrap.
  assign count_i = wr_ptr - rd_ptr;
  assign full_i  = (count_i == DEPTH_C);
  assign empty_i = (count_i == '0);

  // Acceptance uses the start-of-cycle flags, so a read on a full FIFO
  // never makes room for a same-cycle write (and vice versa when empty).
  assign wr_acc = bus.wr_en && !full_i;
  assign rd_acc = bus.rd_en && !empty_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
    end
  end

  // A new error outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_i)       overflow_q <= 1'b1;
      else if (bus.err_clr)          overflow_q <= 1'b0;
      if (bus.rd_en && empty_i)      underflow_q <= 1'b1;
      else if (bus.err_clr)          underflow_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry falls through; masked while empty so reset shows zero
  // instead of stale storage.
  assign bus.data_out   = empty_i ? '0 : ram_rdata;
  assign bus.data_valid = !empty_i;
`else
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= ram_rdata;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
`endif

  assign bus.count        = count_i;
  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (count_i >= AF_C);
  assign bus.almost_empty = (count_i <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + randomized bench for sync_fifo_param,
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk;
  logic rst_n;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_dval;
  logic [DW-1:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_dval = 0;
    m_dout = '0;
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] exp_dout;
    bit exp_dval;
    n = q.size();
`ifdef FIFO_FWFT_EN
    exp_dout = (n != 0) ? q[0] : '0;
    exp_dval = (n != 0);
`else
    exp_dout = m_dout;
    exp_dval = m_dval;
`endif
    chk("count",        32'(bus.count),        32'(n));
    chk("full",         32'(bus.full),         32'(n == DEPTH));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_udf));
    chk("data_out",     32'(bus.data_out),     32'(exp_dout));
    chk("data_valid",   32'(bus.data_valid),   32'(exp_dval));
  endtask

  // One clock: drive inputs, predict from the pre-edge model state, check after the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full, was_empty, wacc, racc;
    logic [DW-1:0] popped;
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.err_clr = c;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wacc = w && !was_full;
    racc = r && !was_empty;
    popped = '0;
    @(posedge clk);
    #1;
    if (racc) popped = q.pop_front();
    if (wacc) q.push_back(d);
    if (w && was_full)       m_ovf = 1;
    else if (c)              m_ovf = 0;
    if (r && was_empty)      m_udf = 1;
    else if (c)              m_udf = 0;
    m_dval = racc;
    if (racc) m_dout = popped;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    check_all();
  endtask

  task automatic drain();
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) cycle(0, '0, 1, 0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = '0;
    rst_n       = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // fill with 0x01..0x10, then drain in order
    for (int i = 1; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0);
    drain();

    // overflow: fill, write 0xAA while full, then write-while-full with err_clr
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hAA, 0, 0);
    cycle(1, 8'hAA, 0, 1);
    cycle(0, '0, 0, 1);
    // full + simultaneous read/write: write dropped, read proceeds
    cycle(1, 8'hAA, 1, 0);
    cycle(0, '0, 0, 1);
    drain();

    // underflow on empty, data_out must hold
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 1);
    // empty + simultaneous read/write: read dropped, write proceeds
    cycle(1, 8'h77, 1, 0);
    cycle(0, '0, 0, 1);
    drain();

    // steady state at count 8 across the pointer wrap
    for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 55, 8'($urandom),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    drain();
    cycle(0, '0, 0, 1);

    // asynchronous reset mid-burst at count 5
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0);
    bus.wr_en   = 1'b1;
    bus.data_in = 8'hE1;
    bus.rd_en   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
    cycle(1, 8'h3C, 0, 0);
`ifdef FIFO_FWFT_EN
    chk("first_after_reset", 32'(bus.data_out), 32'h3C);
`endif
    cycle(0, '0, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("first_after_reset", 32'(bus.data_out), 32'h3C);
`endif

`ifdef FIFO_FWFT_EN
    // fall-through: 0x5A appears without rd_en
    cycle(1, 8'h5A, 0, 0);
    chk("fwft_data", 32'(bus.data_out), 32'h5A);
    chk("fwft_valid", 32'(bus.data_valid), 32'h1);
    cycle(0, '0, 0, 0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO; the next generation of the team's 8-bit dual-clock FIFO for same-domain buffering. Adds configurable width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Used between single-clock producer/consumer stages where clock-domain crossing is not required.

## Interface
- DATA_W, 8, word width in bits
- DEPTH, 16, number of entries; power of two, at least 4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- err_clr  in  1  synchronous clear of overflow/underflow
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds a newly popped word (standard mode only; tied 1 when !empty in FWFT)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers are $clog2(DEPTH)+1 bits; the low bits address storage and the MSB is the wrap bit. count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- A write is accepted iff wr_en && !full, using the value of full at the start of the cycle. A read is accepted iff rd_en && !empty.
- Simultaneous wr_en and rd_en while full: the write is dropped and overflow sets; the read proceeds and count becomes DEPTH-1.
- Simultaneous wr_en and rd_en while empty: the read is dropped and underflow sets; the write proceeds and count becomes 1.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0 in storage, and the wrap bit toggles.
- overflow and underflow stay set until err_clr or reset. When err_clr coincides with a new error event, the new error wins and the flag remains 1.
- All flags are decoded from registered pointers, so they reflect the state after the most recent edge.
- Reset (any time, including mid-transfer) sets:
  - pointers = 0, count = 0, empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0
  - Storage contents are not reset.

## Timing
- Standard mode:
  - Read latency is 1 cycle: data_out is registered and updates on the edge that accepts the read.
  - data_valid is high for exactly the cycle after an accepted read; otherwise data_out holds its last value.
- Write-to-not-empty: empty deasserts on the edge after the accepted write.
- Full-to-not-full: full deasserts on the edge after the accepted read.
- A word written in cycle N can be read in cycle N+1 at the earliest.

## Configuration
- FIFO_FWFT_EN:
  - Defined (first-word-fall-through): data_out presents the head entry combinationally from storage whenever !empty, and rd_en acknowledges and pops it. data_valid = !empty. Write-to-data_out latency is 1 cycle.
  - Undefined: standard registered-read behaviour as above.

## Structure
- fifo_pkg holds:
  - default DATA_W/DEPTH constants
  - ptr-width helper function
  - typedef for the pointer (wrap bit + address)
- One sub-module, fifo_ram: a DEPTH x DATA_W simple dual-port array with a write port and an asynchronous read port. The output register lives in sync_fifo_param and is bypassed under FIFO_FWFT_EN.

## Test plan
- Reset, then 16 writes (0x01..0x10, DEPTH=16) -> count 16, full=1, almost_full from count 14.
- Then 16 reads -> data_out 0x01..0x10 in order, empty=1 after the final read, almost_empty from count 2.
- Write while full with 0xAA -> overflow=1, count stays 16, and 0xAA is never read out. Pulse err_clr -> overflow=0.
- Read on empty -> underflow=1, data_valid=0, data_out unchanged.
- Continuous simultaneous read/write at count 8 for 40 cycles, crossing the pointer wrap -> count constant at 8 and data order preserved.
- Assert rst_n low mid-burst at count 5 -> all outputs take reset values immediately. The next write of 0x3C is read back first.
- With FIFO_FWFT_EN: write 0x5A into an empty FIFO -> data_out=0x5A and data_valid=1 one cycle later with no rd_en.
